// File: rtl/seq_alu.sv
// seq_alu -- multi-cycle ALU with add, subtract, shift-add multiply and
// (optionally) restoring divide.
//
// Configuration macro:
//   SEQ_ALU_DIV_EN  defined   -> divider built in; op 011 runs WIDTH+1 cycles
//                   undefined -> no divider; op 011 behaves like the unused
//                                codes (result 0, flags 0100, latency 1)
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high; aborts any operation in flight
//   start       request pulse, honoured only while busy=0
//   ALUControl  000 add, 001 sub, 010 mul, 011 div, 1xx unused
//   SrcA, SrcB  operands, captured in the cycle start is accepted
//   ALUResult   registered result, held between done pulses
//   ALUFlags    registered {N,Z,C,V}, held between done pulses
//   busy        high from acceptance through the done cycle
//   done        one-cycle pulse when ALUResult/ALUFlags update
//
// Latency from the accepting edge to done: 1 for add/sub/unused codes,
// WIDTH+1 for mul and div.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t             state;
  logic [CW-1:0]      cnt;
  // Shared iteration register: for mul it is {partial product high, multiplier
  // shifting out}; for div it is {partial remainder, dividend shifting into
  // quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   a_q;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0]   b_q;
`endif

  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
    return {res[WIDTH-1], res == '0, c, v};
  endfunction

  // Single-cycle operations, evaluated straight from the inputs in the
  // accepting cycle.
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] imm_res;
  logic [3:0]       imm_flags;

  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    add_full  = {1'b0, SrcA} + {1'b0, SrcB};
    sub_full  = {1'b0, SrcA} - {1'b0, SrcB};
    imm_res   = '0;
    imm_flags = make_flags('0, 1'b0, 1'b0);
    case (ALUControl)
      3'b000: begin
        imm_res   = add_full[WIDTH-1:0];
        imm_flags = make_flags(add_full[WIDTH-1:0], add_full[WIDTH],
                               (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                               (add_full[WIDTH-1] != SrcA[WIDTH-1]));
      end
      3'b001: begin
        imm_res   = sub_full[WIDTH-1:0];
        // Top bit of the widened difference is the borrow; C means no borrow.
        imm_flags = make_flags(sub_full[WIDTH-1:0], ~sub_full[WIDTH],
                               (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                               (sub_full[WIDTH-1] != SrcA[WIDTH-1]));
      end
      default: ;
    endcase
  end

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole register right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  // One restoring-division step: bring the next dividend bit into the
  // remainder, subtract the divisor if it fits, shift the quotient bit in.
  // A zero divisor always "fits", so the quotient naturally becomes all ones.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_next  = {div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0],
                 acc[WIDTH-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers take non-blocking assignments only, so every
    // right-hand side sees the pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_q       <= '0;
`ifdef SEQ_ALU_DIV_EN
      b_q       <= '0;
`endif
      ALUResult <= '0;
      ALUFlags  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            case (ALUControl)
              3'b010: begin
                a_q   <= SrcA;
                acc   <= {{WIDTH{1'b0}}, SrcB};
                state <= MUL;
              end
`ifdef SEQ_ALU_DIV_EN
              3'b011: begin
                b_q   <= SrcB;
                acc   <= {{WIDTH{1'b0}}, SrcA};
                state <= DIV;
              end
`endif
              default: begin
                ALUResult <= imm_res;
                ALUFlags  <= imm_flags;
                done      <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end

        MUL: begin
          acc <= mul_next;
          cnt <= cnt + CW'(1);
          // The last step's result is written directly, so done follows the
          // WIDTH-th iteration without an extra cycle.
          if (cnt == LAST) begin
            ALUResult <= mul_next[WIDTH-1:0];
            ALUFlags  <= make_flags(mul_next[WIDTH-1:0], 1'b0,
                                    |mul_next[2*WIDTH-1:WIDTH]);
            done      <= 1'b1;
            state     <= DONE;
          end
        end

`ifdef SEQ_ALU_DIV_EN
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            ALUResult <= div_next[WIDTH-1:0];
            ALUFlags  <= make_flags(div_next[WIDTH-1:0], 1'b0, b_q == '0);
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 32;

`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA, SrcB;
  logic [W-1:0] ALUResult;
  logic [3:0]   ALUFlags;
  logic         busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUResult (ALUResult),
    .ALUFlags  (ALUFlags),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    logic [3:0]   f;
    int           lat;
  } vec_t;

  // Reference model from the arithmetic definitions, using wide integers.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                output logic [W-1:0] r, output logic [3:0] f,
                                output int lat);
    longint sa, sb, t;
    logic [63:0] p;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; r = '0; lat = 1;
    case (op)
      3'd0: begin
        p = 64'(a) + 64'(b);
        r = p[W-1:0];
        c = p[W];
        t = sa + sb;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        t = sa - sb;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd2: begin
        p = 64'(a) * 64'(b);
        r = p[W-1:0];
        v = (p[63:32] != 0);
        lat = W + 1;
      end
      3'd3: begin
        if (DIV_EN) begin
          lat = W + 1;
          if (b == 0) begin r = '1; v = 1'b1; end
          else r = a / b;
        end
      end
      default: ;
    endcase
    f = {r[W-1], r == 0, c, v};
  endfunction

  // Issue one operation from a negedge while idle. After acceptance the
  // operands are scrambled every cycle; on cycle 'poke' start is raised again.
  // Returns at the negedge of the cycle after done, ready for a new start.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, b,
                       input int poke,
                       output logic [W-1:0] res, output logic [3:0] fl,
                       output int lat, output bit busy_ok, output bit one_pulse);
    start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    lat = 0; busy_ok = 1'b1;
    res = '0; fl = '0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      start      = (lat == poke);
      ALUControl = 3'($urandom);
      SrcA       = $urandom;
      SrcB       = $urandom;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
    res = ALUResult; fl = ALUFlags;
    start = 1'b0;
    @(negedge clk);
    one_pulse = !done && !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (ALUResult !== '0) $display("FAIL reset_result got=%h exp=0", ALUResult); else n_pass++;
    if (ALUFlags !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", ALUFlags); else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic [W-1:0] res; logic [3:0] fl; int lat; bit bok, one;
    v.push_back('{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1});
    v.push_back('{3'b001, 32'd5, 32'd5, 32'h00000000, 4'b0110, 1});
    v.push_back('{3'b001, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1000, 1});
    v.push_back('{3'b010, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0101, 33});
    v.push_back('{3'b011, 32'd100, 32'd7, DIV_EN ? 32'h0000000E : 32'h0,
                  DIV_EN ? 4'b0000 : 4'b0100, DIV_EN ? 33 : 1});
    v.push_back('{3'b011, 32'd9, 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'h0,
                  DIV_EN ? 4'b1001 : 4'b0100, DIV_EN ? 33 : 1});
    v.push_back('{3'b101, 32'h12345678, 32'h9, 32'h0, 4'b0100, 1});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, 0, res, fl, lat, bok, one);
      n_checks += 5;
      if (res !== v[i].r) $display("FAIL dir%0d_result got=%h exp=%h", i, res, v[i].r); else n_pass++;
      if (fl !== v[i].f) $display("FAIL dir%0d_flags got=%b exp=%b", i, fl, v[i].f); else n_pass++;
      if (lat != v[i].lat) $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); else n_pass++;
      if (bok !== 1'b1) $display("FAIL dir%0d_busy got=0 exp=1 throughout", i); else n_pass++;
      if (one !== 1'b1) $display("FAIL dir%0d_done_pulse got=done/busy still high exp=idle", i); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, er; logic [3:0] fl, ef; logic [2:0] op;
    int lat, el; bit bok, one;
    logic [W-1:0] edges [5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 4) == 4) ? 3'($urandom) : 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      if (op == 3'd3 && $urandom_range(0, 1) == 1) b = b >> $urandom_range(8, 28);
      model(op, a, b, er, ef, el);
      do_op(op, a, b, 0, res, fl, lat, bok, one);
      n_checks += 3;
      if (res !== er) $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, er); else n_pass++;
      if (fl !== ef) $display("FAIL rnd%0d_flags op=%0d a=%h b=%h got=%b exp=%b", i, op, a, b, fl, ef); else n_pass++;
      if (lat != el) $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, el); else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a, b, res, er; logic [3:0] fl, ef; int lat, el; bit bok, one;
    a = $urandom; b = $urandom_range(1, 32'hFFFF);
    model(3'd2, a, b, er, ef, el);
    do_op(3'd2, a, b, 5, res, fl, lat, bok, one);
    n_checks += 4;
    if (res !== er) $display("FAIL ignore_result got=%h exp=%h", res, er); else n_pass++;
    if (fl !== ef) $display("FAIL ignore_flags got=%b exp=%b", fl, ef); else n_pass++;
    if (lat != el) $display("FAIL ignore_latency got=%0d exp=%0d", lat, el); else n_pass++;
    if (bok !== 1'b1) $display("FAIL ignore_busy got=0 exp=1 throughout"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, res, er; logic [3:0] fl, ef; int lat, el; bit bok, one;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      model(3'(i % 2), a, b, er, ef, el);
      do_op(3'(i % 2), a, b, 0, res, fl, lat, bok, one);
      n_checks += 3;
      if (res !== er) $display("FAIL b2b%0d_result got=%h exp=%h", i, res, er); else n_pass++;
      if (fl !== ef) $display("FAIL b2b%0d_flags got=%b exp=%b", i, fl, ef); else n_pass++;
      if (lat != 1) $display("FAIL b2b%0d_latency got=%0d exp=1", i, lat); else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] res; logic [3:0] fl; int lat; bit bok, one, saw_done;
    start = 1'b1; ALUControl = DIV_EN ? 3'd3 : 3'd2; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    // Reset and a competing start in the same cycle: reset must win.
    reset = 1'b1; start = 1'b1; ALUControl = 3'd0; SrcA = 32'd1; SrcB = 32'd2;
    @(negedge clk);
    n_checks += 4;
    if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
    if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else n_pass++;
    if (ALUResult !== '0) $display("FAIL abort_result got=%h exp=0", ALUResult); else n_pass++;
    if (ALUFlags !== 4'b0) $display("FAIL abort_flags got=%b exp=0000", ALUFlags); else n_pass++;
    reset = 1'b0; start = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL abort_quiet got=activity exp=idle"); else n_pass++;
    do_op(3'd0, 32'd10, 32'd20, 0, res, fl, lat, bok, one);
    n_checks += 3;
    if (res !== 32'd30) $display("FAIL abort_add_result got=%h exp=%h", res, 32'd30); else n_pass++;
    if (fl !== 4'b0000) $display("FAIL abort_add_flags got=%b exp=0000", fl); else n_pass++;
    if (lat != 1) $display("FAIL abort_add_latency got=%0d exp=1", lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
